// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller command port.
// A granted command is held on the controller until it is acknowledged or the wait times out.
module sdram_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_stb_rd,
    input  logic        p0_stb_wt,
    input  logic [23:0] p0_adr,
    input  logic [15:0] p0_wdata,
    input  logic        p1_stb_rd,
    input  logic        p1_stb_wt,
    input  logic [23:0] p1_adr,
    input  logic [15:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p_err,
    output logic [15:0] p_rdata,
    output logic        busy,
    output logic        grant,
    output logic [23:0] sd_adr,
    output logic [15:0] sd_data,
    output logic        sd_stb_rd,
    output logic        sd_stb_wt,
    input  logic        sd_ack,
    input  logic [15:0] sd_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       req0;
    logic       req1;
    logic       win;
    logic       op_rd;
    logic       timeout_hit;
    logic [7:0] cnt;

    assign req0        = p0_stb_rd | p0_stb_wt;
    assign req1        = p1_stb_rd | p1_stb_wt;
    assign timeout_hit = (cnt == CNT_LAST);

    // On a tie the port that did not win last time goes first.
    always_comb begin
        state_nxt = state;
        win       = (req0 && req1) ? ~grant : req1;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ISSUE;
            ISSUE:   if (sd_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 1'b1;
            op_rd   <= 1'b0;
            cnt     <= 8'd0;
            sd_adr  <= 24'd0;
            sd_data <= 16'd0;
            p_rdata <= 16'd0;
            p_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= win;
                        sd_adr  <= win ? p1_adr : p0_adr;
                        sd_data <= win ? p1_wdata : p0_wdata;
                        op_rd   <= win ? p1_stb_rd : p0_stb_rd;
                        cnt     <= 8'd0;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 8'd1;
                    // A controller ack in the timeout cycle still counts as success.
                    if (sd_ack) begin
                        if (op_rd) p_rdata <= sd_rdata;
                        p_err <= 1'b0;
                    end else if (timeout_hit) begin
                        p_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_stb_rd = (state == ISSUE) & op_rd;
    assign sd_stb_wt = (state == ISSUE) & ~op_rd;
    assign busy      = (state != IDLE);
    assign p0_ack    = (state == DONE) & ~grant;
    assign p1_ack    = (state == DONE) & grant;

endmodule
